ntt_r16_addr_gen: RTL
=====================

Name: ntt_r16_addr_gen

Overview:
- Upstream control stage of the radix-16 NTT datapath; drives the read and write address/bank inputs of memory_wrapper.
- Walks every stage and every butterfly group of an N = 16^STAGES point transform.
- Emits 16 conflict-free (MA, BN) pairs per group, with one read per cycle.
- Produces the matching write-back indices after the butterfly pipeline latency, and flags the final stage.

Parameters:
- STAGES, 3, number of radix-16 stages; N = 16^STAGES, groups per stage G = 16^(STAGES-1).
- MA_WIDTH, 4*(STAGES-1), width of one memory address index (matches `MA_width).
- BANK_WIDTH, 4, width of one bank index (matches `BANK_width); 16 banks.
- PIPE_LAT, 8, cycles from memory read request to butterfly result being ready for write; range 1..31.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a full transform; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the final write has been issued.
- LAST_STAGE  out  1  high while the final stage is being read or written.
- stage_idx  out  $clog2(STAGES)  current stage number.
- r_enable  out  1  read request for the 16 lanes.
- MA_idx  out  16*MA_WIDTH  read memory address; lane k is at [k*MA_WIDTH +: MA_WIDTH].
- BN_idx  out  16*BANK_WIDTH  read bank index per lane.
- w_enable  out  1  write request, equal to r_enable delayed by PIPE_LAT cycles.
- R16_w_MA_idx  out  16*MA_WIDTH  write memory address per lane.
- R16_w_BN_idx  out  16*BANK_WIDTH  write bank index per lane.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. Every output is 0, and the whole delay line is cleared.
- FSM states: IDLE -> READ on start. READ -> DRAIN after group G-1. DRAIN -> READ (next stage) after PIPE_LAT cycles, or DRAIN -> DONE after the final stage. DONE -> IDLE after one cycle.
- Cycle numbering: cycle 0 is the edge on which start is sampled.
- Stage s reads occupy cycles s*(G+PIPE_LAT)+1 through s*(G+PIPE_LAT)+G.
- done is high in cycle STAGES*(G+PIPE_LAT)+1 only.
- Point index for stage s, group g, lane k: j = the base-16 digits of g with digit k inserted at digit position s. Example: s=0 gives j = g*16 + k.
- MA = j >> 4, truncated to MA_WIDTH.
- BN = (sum of the base-16 digits of j) mod 16. This guarantees the 16 BN values within a group are distinct.
- All outputs are registered; the combinational index math runs on the counters.
- Write path: a PIPE_LAT-deep shift register carries {r_enable, MA_idx, BN_idx}.
- The last write of stage s is issued one cycle before the first read of stage s+1, so there is no read-after-write hazard.
- LAST_STAGE and stage_idx change on the first read cycle of a stage. They hold through that stage's drain, so the writes of a stage see that stage's value.
- A start pulse while busy=1 has no effect.
- A reset mid-run aborts immediately. No done pulse is produced, and the next start begins from stage 0.
- Counters wrap only under FSM control. The group counter is G-1 max, and the stage counter is STAGES-1 max.

Optional Feature:
- Macro: NTT_AG_STALL_EN.
- Defined: adds a 1-bit input port stall.
  - While stall=1: the FSM, the group and drain counters, and the delay line all hold.
  - r_enable and w_enable are forced to 0 for that cycle; index outputs hold their values.
  - Held entries resume their remaining latency when stall returns to 0.
  - done timing extends by exactly the number of stalled cycles.
- Undefined: no stall port, and the block free-runs as described above.

Test Plan (STAGES=3, PIPE_LAT=8, G=256):
- Reset then start at cycle 0 -> r_enable high in cycles 1..256, 265..520 and 529..784. done pulses only in cycle 793, and busy falls with it.
- Cycle 1 (stage 0, group 0) -> MA lanes all 0, and BN lane k = k. Cycle 2 (group 1) -> MA=1, and BN lane k = (1+k) mod 16.
- Cycle 265 (stage 1, group 0) -> MA lane k = k, BN lane k = k, LAST_STAGE=0. Cycle 529 -> MA lane k = 16k, BN lane k = k, LAST_STAGE=1.
- Every read cycle -> the 16 BN values are pairwise distinct. w_enable and R16_w indices equal the read values from 8 cycles earlier, and all 4096 (BN, MA) pairs are written exactly once per stage.
- rst driven low at cycle 300, released at 305, then start at 310 -> all outputs 0 during reset, no done pulse, and the rerun reads stage 0 group 0 in cycle 311. A start at cycle 100 of a run is ignored.
- With NTT_AG_STALL_EN, stall high for cycles 50..59 -> no r_enable or w_enable in those cycles, and done pulses at 803.

Source files
------------

// File: rtl/ntt_r16_addr_gen_if.sv
// Control and address bundle between ntt_r16_addr_gen and memory_wrapper.
// master = address generator, slave = memory side.
interface ntt_r16_addr_gen_if #(
  parameter int STAGES     = 3,
  parameter int MA_WIDTH   = 4*(STAGES-1),
  parameter int BANK_WIDTH = 4
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    LAST_STAGE;
  logic [SW-1:0]           stage_idx;
  logic                    r_enable;
  logic [16*MA_WIDTH-1:0]  MA_idx;
  logic [16*BANK_WIDTH-1:0] BN_idx;
  logic                    w_enable;
  logic [16*MA_WIDTH-1:0]  R16_w_MA_idx;
  logic [16*BANK_WIDTH-1:0] R16_w_BN_idx;

  modport master (
    input  start,
    output busy, done, LAST_STAGE, stage_idx,
    output r_enable, MA_idx, BN_idx,
    output w_enable, R16_w_MA_idx, R16_w_BN_idx
  );

  modport slave (
    output start,
    input  busy, done, LAST_STAGE, stage_idx,
    input  r_enable, MA_idx, BN_idx,
    input  w_enable, R16_w_MA_idx, R16_w_BN_idx
  );
endinterface

// File: rtl/ntt_r16_addr_gen.sv
// Radix-16 NTT read/write address generator, one group per cycle.
// Optional NTT_AG_STALL_EN adds a stall input that freezes the whole block.
module ntt_r16_addr_gen #(
  parameter int STAGES     = 3,
  parameter int MA_WIDTH   = 4*(STAGES-1),
  parameter int BANK_WIDTH = 4,
  parameter int PIPE_LAT   = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef NTT_AG_STALL_EN
  input  logic stall,
`endif
  ntt_r16_addr_gen_if.master ag
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int GW = 4*(STAGES-1);
  localparam int JW = 4*STAGES;
  localparam int MW = 16*MA_WIDTH;
  localparam int BW = 16*BANK_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic          en;
    logic [MW-1:0] ma;
    logic [BW-1:0] bn;
  } wr_t;

  logic adv;
`ifdef NTT_AG_STALL_EN
  assign adv = ~stall;
`else
  assign adv = 1'b1;
`endif

  state_t        state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [SW-1:0] stg_q, stg_d;
  logic [4:0]    dcnt_q, dcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ren_q, ren_d;
  logic [MW-1:0] ma_q, ma_d, ma_c;
  logic [BW-1:0] bn_q, bn_d, bn_c;
  logic [SW-1:0] sidx_q, sidx_d;
  logic          last_q, last_d;
  wr_t           dl_q [PIPE_LAT];
  wr_t           dl_d [PIPE_LAT];

  logic [JW-1:0] gx, lo, j;
  logic [3:0]    dsum;
  logic          last_stg;

  assign last_stg = (stg_q == SW'(STAGES-1));

  // Lane k digit is spliced in at digit position stg_q; BN is the digit sum.
  always_comb begin
    gx   = JW'(grp_q);
    lo   = (JW'(1) << (4*stg_q)) - JW'(1);
    j    = '0;
    dsum = '0;
    ma_c = '0;
    bn_c = '0;
    for (int i = 0; i < STAGES-1; i++)
      dsum = dsum + grp_q[4*i +: 4];
    for (int k = 0; k < 16; k++) begin
      j = ((gx & ~lo) << 4) | (JW'(k) << (4*stg_q)) | (gx & lo);
      ma_c[k*MA_WIDTH +: MA_WIDTH]   = MA_WIDTH'(j >> 4);
      bn_c[k*BANK_WIDTH +: BANK_WIDTH] = BANK_WIDTH'(dsum + 4'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    stg_d   = stg_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ren_d   = 1'b0;
    ma_d    = ma_q;
    bn_d    = bn_q;
    sidx_d  = sidx_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (ag.start) begin
          state_d = S_READ;
          grp_d   = '0;
          stg_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_READ: begin
        ren_d  = 1'b1;
        ma_d   = ma_c;
        bn_d   = bn_c;
        sidx_d = stg_q;
        last_d = last_stg;
        if (&grp_q) begin
          grp_d   = '0;
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 5'(PIPE_LAT-1)) begin
          if (last_stg) begin
            state_d = S_DONE;
          end else begin
            stg_d   = stg_q + SW'(1);
            state_d = S_READ;
          end
        end else begin
          dcnt_d = dcnt_q + 5'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        sidx_d  = '0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dl_d[0].en = ren_q;
    dl_d[0].ma = ma_q;
    dl_d[0].bn = bn_q;
    for (int i = 1; i < PIPE_LAT; i++)
      dl_d[i] = dl_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      stg_q   <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      ma_q    <= '0;
      bn_q    <= '0;
      sidx_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++)
        dl_q[i] <= '0;
    end else if (adv) begin
      state_q <= state_d;
      grp_q   <= grp_d;
      stg_q   <= stg_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ren_q   <= ren_d;
      ma_q    <= ma_d;
      bn_q    <= bn_d;
      sidx_q  <= sidx_d;
      last_q  <= last_d;
      for (int i = 0; i < PIPE_LAT; i++)
        dl_q[i] <= dl_d[i];
    end
  end

  // Held strobes are masked so a frozen entry is issued once, after the stall.
  assign ag.busy         = busy_q;
  assign ag.done         = done_q & adv;
  assign ag.LAST_STAGE   = last_q;
  assign ag.stage_idx    = sidx_q;
  assign ag.r_enable     = ren_q & adv;
  assign ag.MA_idx       = ma_q;
  assign ag.BN_idx       = bn_q;
  assign ag.w_enable     = dl_q[PIPE_LAT-1].en & adv;
  assign ag.R16_w_MA_idx = dl_q[PIPE_LAT-1].ma;
  assign ag.R16_w_BN_idx = dl_q[PIPE_LAT-1].bn;
endmodule
